op_scheduler: RTL and testbench

- Shares one select_action datapath among N_REQ requesters.
- Each requester submits an operation (opr_mode_t opcode plus word_t operand) over a valid/ready handshake.
- A round-robin arbiter grants one request at a time. The FSM drives the datapath's SELECTOR/SW, waits out its pipeline latency, captures LED, and returns the result tagged with the requester id over a valid/ready response channel.

---
 rtl/types_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/op_scheduler.sv | 96 +++++++++
 tb/tb_op_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// types_pkg: shared datapath word, opcode and scheduler state types
package types_pkg;
  localparam int BITS = 16;
  typedef logic [BITS-1:0] word_t;
  typedef enum logic [2:0] {RESET, ADD, SUB, MUL, LEADING_ONES, COUNT_ONES} opr_mode_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;
  function automatic logic is_legal_op(opr_mode_t op);
    return op inside {RESET, ADD, SUB, MUL, LEADING_ONES, COUNT_ONES};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);
  logic [ID_W-1:0] j;
  // scan from ptr upward with wrap, keeping the first hit
  always_comb begin
    any = 1'b0;
    grant_idx = '0;
    j = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = ID_W'((int'(ptr) + i) % N_REQ);
      if (enable && !any && req[j]) begin
        any = 1'b1;
        grant_idx = j;
      end
    end
    grant_onehot = any ? N_REQ'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/op_scheduler.sv
// op_scheduler: shares one select_action datapath among N_REQ round-robin requesters
module op_scheduler
  import types_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int LATENCY = 2,
  parameter int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  opr_mode_t        req_op [N_REQ],
  input  word_t            req_data [N_REQ],
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output word_t            rsp_data,
  output logic [ID_W-1:0]  rsp_id,
  output logic             rsp_err,
  output opr_mode_t        dp_selector,
  output word_t            dp_sw,
  input  word_t            dp_led,
  output logic             busy
);
  localparam int CW = $clog2(LATENCY + 1);
  sched_state_t state, state_n;
  logic [ID_W-1:0] rr_ptr, g_idx, ptr_next;
  logic [CW-1:0] cnt;
  logic any, idle, done, issue_op;
  opr_mode_t g_op;
  assign idle = state == IDLE;
  assign g_op = req_op[g_idx];
  assign issue_op = is_legal_op(g_op) && g_op != RESET;
  assign done = cnt == CW'(1);
  assign ptr_next = (g_idx == ID_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .enable(idle && !rst),
    .grant_onehot(req_ready),
    .grant_idx(g_idx),
    .any(any)
  );
  // next state: RESET and illegal opcodes bypass the datapath straight to RESP
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any) state_n = issue_op ? ISSUE : RESP;
      ISSUE:   state_n = WAIT;
      WAIT:    if (done) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // grant capture, datapath drive, latency countdown and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= '0;
      rsp_err <= 1'b0;
      dp_selector <= RESET;
      dp_sw <= '0;
      busy <= 1'b0;
    end else begin
      rsp_valid <= state_n == RESP;
      busy <= state_n != IDLE;
      if (idle && any) begin
        rr_ptr <= ptr_next;
        rsp_id <= g_idx;
        rsp_data <= '0;
        rsp_err <= !is_legal_op(g_op);
        if (issue_op) begin
          dp_selector <= g_op;
          dp_sw <= req_data[g_idx];
        end
      end
      if (state == ISSUE) cnt <= CW'(LATENCY);
      if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        if (done) begin
          rsp_data <= dp_led;
          dp_selector <= RESET;
          dp_sw <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_op_scheduler.sv
// tb_op_scheduler: scoreboard bench for op_scheduler with a latency-matched datapath stand-in
module tb_op_scheduler;
  import types_pkg::*;
  localparam int N_REQ = 2;
  localparam int LATENCY = 2;
  localparam int ID_W = 1;
  typedef struct packed {word_t data; logic [ID_W-1:0] id; logic err;} exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [N_REQ-1:0] req_valid, req_ready;
  opr_mode_t req_op [N_REQ];
  word_t req_data [N_REQ];
  logic rsp_valid, rsp_ready, rsp_err, busy;
  word_t rsp_data, dp_sw, dp_led;
  logic [ID_W-1:0] rsp_id;
  opr_mode_t dp_selector;
  word_t pipe [LATENCY];
  exp_t sb[$];
  exp_t e;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  op_scheduler #(.N_REQ(N_REQ), .LATENCY(LATENCY), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err), .dp_selector(dp_selector),
    .dp_sw(dp_sw), .dp_led(dp_led), .busy(busy)
  );

  function automatic word_t dp_model(opr_mode_t s, word_t w);
    word_t r;
    logic run;
    r = '0;
    run = 1'b1;
    if (s == COUNT_ONES) r = word_t'($countones(w));
    else if (s == LEADING_ONES)
      for (int i = BITS - 1; i >= 0; i--) begin
        run &= w[i];
        r += word_t'(run);
      end
    else if (s != RESET) r = w;
    return r;
  endfunction

  // datapath stand-in: LATENCY register stages between SELECTOR/SW and LED
  always_ff @(posedge clk) begin
    pipe[0] <= dp_model(dp_selector, dp_sw);
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_led = pipe[LATENCY-1];

  // response scoreboard: every accepted response must match the oldest expectation
  always @(negedge clk) begin
    #2;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected: got data=%h id=%0d err=%0b, required no response", rsp_data, rsp_id, rsp_err);
      end else begin
        e = sb.pop_front();
        if ({rsp_data, rsp_id, rsp_err} !== e) begin
          miscompares++;
          $display("FAIL rsp_match: got data=%h id=%0d err=%0b, required data=%h id=%0d err=%0b",
                   rsp_data, rsp_id, rsp_err, e.data, e.id, e.err);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    req_valid = '1;
    req_op[0] = COUNT_ONES; req_op[1] = COUNT_ONES;
    req_data[0] = 16'h0001; req_data[1] = 16'h0001;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL reset_req_ready: got %b, required 00", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    vectors++; if (rsp_data !== '0) begin miscompares++; $display("FAIL reset_rsp_data: got %h, required 0", rsp_data); end
    vectors++; if (rsp_id !== '0) begin miscompares++; $display("FAIL reset_rsp_id: got %0d, required 0", rsp_id); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b, required 0", rsp_err); end
    vectors++; if (dp_selector !== RESET) begin miscompares++; $display("FAIL reset_dp_selector: got %0d, required 0", dp_selector); end
    vectors++; if (dp_sw !== '0) begin miscompares++; $display("FAIL reset_dp_sw: got %h, required 0", dp_sw); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
  endtask

  task automatic test_count_ones;
    int lat;
    @(negedge clk);
    req_valid = 2'b01; req_op[0] = COUNT_ONES; req_data[0] = 16'h00FF; rsp_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL c1_grant: got %b, required 01", req_ready); end
    sb.push_back(exp_t'{16'd8, 1'b0, 1'b0});
    @(negedge clk);
    req_valid = '0;
    lat = 1;
    #1;
    vectors++; if (dp_selector !== COUNT_ONES || dp_sw !== 16'h00FF || busy !== 1'b1) begin
      miscompares++; $display("FAIL c1_issue: got sel=%0d sw=%h busy=%b, required sel=5 sw=00ff busy=1", dp_selector, dp_sw, busy);
    end
    while (rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    vectors++; if (lat != 4) begin miscompares++; $display("FAIL c1_latency: got %0d cycles, required 4", lat); end
    @(negedge clk); #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL c1_rsp_drop: got %b, required 0", rsp_valid); end
  endtask

  task automatic test_backpressure;
    int lat;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 2'b10; req_op[1] = LEADING_ONES; req_data[1] = 16'hF000;
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_grant: got %b, required 10", req_ready); end
    sb.push_back(exp_t'{16'd4, 1'b1, 1'b0});
    @(negedge clk);
    req_valid = 2'b11; req_op[0] = COUNT_ONES; req_data[0] = 16'h0001;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      #1;
      vectors++; if (req_ready !== '0) begin miscompares++; $display("FAIL bp_ready_busy: got %b, required 00", req_ready); end
      @(negedge clk); lat++;
    end
    vectors++; if (lat != 4) begin miscompares++; $display("FAIL bp_latency: got %0d cycles, required 4", lat); end
    repeat (5) begin
      #1;
      vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 16'd4 || rsp_id !== 1'b1 || rsp_err !== 1'b0 || req_ready !== '0) begin
        miscompares++; $display("FAIL bp_hold: got valid=%b data=%h id=%0d err=%b ready=%b, required valid=1 data=0004 id=1 err=0 ready=00",
                                rsp_valid, rsp_data, rsp_id, rsp_err, req_ready);
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_rsp_drop: got %b, required 0", rsp_valid); end
  endtask

  task automatic test_back_to_back;
    word_t d [2][2];
    word_t x [2][2];
    int idx [2];
    int order[$];
    int gc[$];
    int pend;
    d = '{'{16'h0001, 16'h0007}, '{16'h0003, 16'h000F}};
    x = '{'{16'd1, 16'd3}, '{16'd2, 16'd4}};
    idx = '{0, 0};
    pend = -1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 80 && (order.size() < 4 || sb.size() > 0); c++) begin
      @(negedge clk);
      if (pend >= 0) begin idx[pend]++; pend = -1; end
      for (int k = 0; k < 2; k++) begin
        req_valid[k] = idx[k] < 2;
        req_op[k] = COUNT_ONES;
        if (idx[k] < 2) req_data[k] = d[k][idx[k]];
      end
      #1;
      for (int k = 0; k < 2; k++)
        if (req_ready[k] === 1'b1 && idx[k] < 2) begin
          order.push_back(k);
          gc.push_back(c);
          sb.push_back(exp_t'{x[k][idx[k]], ID_W'(k), 1'b0});
          pend = k;
        end
    end
    req_valid = '0;
    vectors++; if (order.size() != 4) begin miscompares++; $display("FAIL b2b_grants: got %0d grants, required 4", order.size()); end
    for (int i = 0; i < order.size(); i++) begin
      vectors++; if (order[i] != i % 2) begin miscompares++; $display("FAIL b2b_order[%0d]: got %0d, required %0d", i, order[i], i % 2); end
    end
    for (int i = 1; i < gc.size(); i++) begin
      vectors++; if (gc[i] - gc[i-1] != LATENCY + 3) begin
        miscompares++; $display("FAIL b2b_spacing[%0d]: got %0d cycles, required %0d", i, gc[i] - gc[i-1], LATENCY + 3);
      end
    end
  endtask

  task automatic test_bypass(input opr_mode_t op, input logic err, input string tag);
    int lat;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 2'b01; req_op[0] = op; req_data[0] = 16'hFFFF;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL %s_grant: got %b, required 01", tag, req_ready); end
    sb.push_back(exp_t'{16'd0, 1'b0, err});
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = '0;
      lat++;
      #1;
      vectors++; if (dp_selector !== RESET || dp_sw !== '0) begin
        miscompares++; $display("FAIL %s_dp_idle: got sel=%0d sw=%h, required sel=0 sw=0000", tag, dp_selector, dp_sw);
      end
    end while (rsp_valid !== 1'b1 && lat < 20);
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL %s_latency: got %0d cycles, required 1", tag, lat); end
    vectors++; if (rsp_err !== err) begin miscompares++; $display("FAIL %s_err: got %b, required %b", tag, rsp_err, err); end
    @(negedge clk); #1;
    vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL %s_done: got valid=%b busy=%b, required 0 0", tag, rsp_valid, busy);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 2'b01; req_op[0] = COUNT_ONES; req_data[0] = 16'hFFFF;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rm_grant: got %b, required 01", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    vectors++; if (busy !== 1'b1 || dp_selector !== COUNT_ONES) begin
      miscompares++; $display("FAIL rm_in_wait: got busy=%b sel=%0d, required busy=1 sel=5", busy, dp_selector);
    end
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    vectors++; if (busy !== 1'b0 || dp_selector !== RESET || dp_sw !== '0 || rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0 || req_ready !== '0) begin
      miscompares++; $display("FAIL rm_async: got busy=%b sel=%0d sw=%h valid=%b data=%h err=%b ready=%b, required all zero",
                              busy, dp_selector, dp_sw, rsp_valid, rsp_data, rsp_err, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    repeat (8) begin
      @(negedge clk); #1;
      vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL rm_quiet: got valid=%b busy=%b, required 0 0", rsp_valid, busy);
      end
    end
    @(negedge clk);
    req_valid = 2'b11;
    req_op[0] = COUNT_ONES; req_op[1] = COUNT_ONES;
    req_data[0] = 16'h0001; req_data[1] = 16'h0003;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rm_ptr_reset: got %b, required 01", req_ready); end
    sb.push_back(exp_t'{16'd1, 1'b0, 1'b0});
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_count_ones();
    test_backpressure();
    test_back_to_back();
    test_bypass(RESET, 1'b0, "rst_op");
    test_bypass(opr_mode_t'(3'b111), 1'b1, "illegal");
    test_reset_mid();
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin @(negedge clk); #3; end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
